operand_collector: RTL and testbench



---
 rtl/operand_collector_pkg.sv | 6 +
 rtl/operand_collector_if.sv | 29 ++
 rtl/operand_collector_slot.sv | 34 +++
 rtl/operand_collector.sv | 88 ++++++++
 tb/tb_operand_collector.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/operand_collector_pkg.sv
// operand_collector_pkg: shared types for the operand collector
// mode_t selects the reduction; state_t encodes the collect/compute/hold sequence.
package operand_collector_pkg;
  typedef enum logic [1:0] {MODE_SUM, MODE_MAX, MODE_MIN, MODE_XOR} mode_t;
  typedef enum logic [1:0] {ST_COLLECT, ST_COMPUTE, ST_HOLD} state_t;
endpackage

// File: rtl/operand_collector_if.sv
// operand_collector_if: operand entry and result handshake bundle
// master drives d_in/sel/capture/abort/mode/result_ack;
// slave drives ready/slot_valid/result/valid/dup_err.
interface operand_collector_if import operand_collector_pkg::*; #(
  parameter int DATA_W  = 4,
  parameter int NUM_OPS = 4
) ();
  localparam int SEL_W = $clog2(NUM_OPS);
  localparam int RES_W = DATA_W + $clog2(NUM_OPS);
  logic [DATA_W-1:0]  d_in;
  logic [SEL_W-1:0]   sel;
  logic               capture;
  logic               abort;
  mode_t              mode;
  logic               result_ack;
  logic               ready;
  logic [NUM_OPS-1:0] slot_valid;
  logic [RES_W-1:0]   result;
  logic               valid;
  logic               dup_err;
  modport master (
    output d_in, sel, capture, abort, mode, result_ack,
    input  ready, slot_valid, result, valid, dup_err
  );
  modport slave (
    input  d_in, sel, capture, abort, mode, result_ack,
    output ready, slot_valid, result, valid, dup_err
  );
endinterface

// File: rtl/operand_collector_slot.sv
// opcol_slot: one operand register with valid flag and overwrite detect
// wr_i loads d_i and sets valid; clr_i drops valid (wins over wr_i);
// dup_o flags a write landing on an already-valid slot.
module opcol_slot #(
  parameter int DATA_W = 4
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              wr_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o,
  output logic              valid_o,
  output logic              dup_o
);
  logic [DATA_W-1:0] q_q, q_d;
  logic              valid_q, valid_d;
  always_comb begin
    q_d     = wr_i ? d_i : q_q;
    valid_d = clr_i ? 1'b0 : (valid_q | wr_i);
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      q_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end
  assign q_o     = q_q;
  assign valid_o = valid_q;
  assign dup_o   = wr_i & valid_q;
endmodule

// File: rtl/operand_collector.sv
// operand_collector: captures NUM_OPS operands, reduces them, holds the result until acked
// clock/rst plain; bus (slave) carries operand entry, mode, and result handshake.
module operand_collector import operand_collector_pkg::*; #(
  parameter int DATA_W  = 4,
  parameter int NUM_OPS = 4
) (
  input logic              clock,
  input logic              rst,
  operand_collector_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_OPS);
  localparam int RES_W = DATA_W + $clog2(NUM_OPS);
  state_t             state_q, state_d;
  logic [RES_W-1:0]   result_q, result_d, red, ext;
  logic               valid_q, valid_d, dup_err_q, dup_err_d;
  logic [DATA_W-1:0]  data [NUM_OPS];
  logic [NUM_OPS-1:0] vld, wr, dup, vld_next;
  logic               collect, cap_ok, clr;
  assign collect = state_q == ST_COLLECT;
  // Out-of-range selects only exist for non-power-of-2 slot counts.
  assign cap_ok  = collect & bus.capture & ~bus.abort
                 & ({1'b0, bus.sel} < (SEL_W+1)'(NUM_OPS));
  assign clr     = (state_q == ST_COMPUTE) | (collect & bus.abort);
  genvar i;
  for (i = 0; i < NUM_OPS; i++) begin : g_slot
    assign wr[i] = cap_ok & (bus.sel == SEL_W'(i));
    opcol_slot #(.DATA_W(DATA_W)) u_slot (
      .clock  (clock),
      .rst    (rst),
      .wr_i   (wr[i]),
      .clr_i  (clr),
      .d_i    (bus.d_in),
      .q_o    (data[i]),
      .valid_o(vld[i]),
      .dup_o  (dup[i])
    );
  end
  // Slot flags as they will be after this edge; all-ones moves us to COMPUTE.
  assign vld_next = bus.abort ? '0 : (vld | wr);
  always_comb begin
    red = RES_W'(data[0]);
    ext = '0;
    for (int j = 1; j < NUM_OPS; j++) begin
      ext = RES_W'(data[j]);
      red = bus.mode == MODE_SUM ? red + ext :
            bus.mode == MODE_MAX ? (ext > red ? ext : red) :
            bus.mode == MODE_MIN ? (ext < red ? ext : red) :
                                   red ^ ext;
    end
  end
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    valid_d   = valid_q;
    dup_err_d = dup_err_q | (|dup);
    unique case (state_q)
      ST_COLLECT: if (&vld_next) state_d = ST_COMPUTE;
      ST_COMPUTE: begin
        state_d  = ST_HOLD;
        result_d = red;
        valid_d  = 1'b1;
      end
      ST_HOLD: if (bus.result_ack) begin
        state_d = ST_COLLECT;
        valid_d = 1'b0;
      end
      default: state_d = ST_COLLECT;
    endcase
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q   <= ST_COLLECT;
      result_q  <= '0;
      valid_q   <= 1'b0;
      dup_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      dup_err_q <= dup_err_d;
    end
  end
  assign bus.ready      = collect;
  assign bus.slot_valid = vld;
  assign bus.result     = result_q;
  assign bus.valid      = valid_q;
  assign bus.dup_err    = dup_err_q;
endmodule

// File: tb/tb_operand_collector.sv
// tb_operand_collector: directed bench for a 4x4-bit and a 3x8-bit operand collector
module tb_operand_collector;
  import operand_collector_pkg::*;
  logic clock = 1'b0;
  logic rst = 1'b1;
  always #5 clock = ~clock;
  int cap[2], sel[2], d[2], abt[2], md[2], ack[2];
  int a_rdy[2], a_vld[2], a_sv[2], a_res[2], a_dup[2];
  int n_ops[2] = '{4, 3};
  int m_ph[2], m_mask[2], m_vo[2], m_dup[2], m_res[2];
  int m_vals[2][16];
  int pass_cnt = 0, total_cnt = 0;
  bit chk_en = 1'b0;
  operand_collector_if #(.DATA_W(4), .NUM_OPS(4)) ia ();
  operand_collector_if #(.DATA_W(8), .NUM_OPS(3)) ib ();
  assign ia.capture    = cap[0] != 0;
  assign ia.sel        = sel[0][1:0];
  assign ia.d_in       = d[0][3:0];
  assign ia.abort      = abt[0] != 0;
  assign ia.mode       = mode_t'(md[0][1:0]);
  assign ia.result_ack = ack[0] != 0;
  assign ib.capture    = cap[1] != 0;
  assign ib.sel        = sel[1][1:0];
  assign ib.d_in       = d[1][7:0];
  assign ib.abort      = abt[1] != 0;
  assign ib.mode       = mode_t'(md[1][1:0]);
  assign ib.result_ack = ack[1] != 0;
  assign a_rdy[0] = int'(ia.ready);
  assign a_vld[0] = int'(ia.valid);
  assign a_sv[0]  = int'(ia.slot_valid);
  assign a_res[0] = int'(ia.result);
  assign a_dup[0] = int'(ia.dup_err);
  assign a_rdy[1] = int'(ib.ready);
  assign a_vld[1] = int'(ib.valid);
  assign a_sv[1]  = int'(ib.slot_valid);
  assign a_res[1] = int'(ib.result);
  assign a_dup[1] = int'(ib.dup_err);
  operand_collector #(.DATA_W(4), .NUM_OPS(4)) u_a (.clock(clock), .rst(rst), .bus(ia));
  operand_collector #(.DATA_W(8), .NUM_OPS(3)) u_b (.clock(clock), .rst(rst), .bus(ib));
  function automatic int reduce(input int v[16], input int n, input int mdv);
    int r = (mdv == 1 || mdv == 2) ? v[0] : 0;
    for (int i = 0; i < n; i++)
      case (mdv)
        0: r = r + v[i];
        1: r = v[i] > r ? v[i] : r;
        2: r = v[i] < r ? v[i] : r;
        default: r = r ^ v[i];
      endcase
    return r;
  endfunction
  task automatic check(input int k, input string nm, input int act, input int exp);
    total_cnt++;
    if (act != exp) $display("FAIL dut%0d %s: got %0d expected %0d at %0t", k, nm, act, exp, $time);
    else pass_cnt++;
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      int ph, mk, vo, dp, rs;
      int v[16];
      ph = m_ph[k]; mk = m_mask[k]; vo = m_vo[k]; dp = m_dup[k]; rs = m_res[k];
      v = m_vals[k];
      if (rst) begin
        ph = 0; mk = 0; vo = 0; dp = 0; rs = 0;
        for (int i = 0; i < 16; i++) v[i] = 0;
      end else if (ph == 0) begin
        if (abt[k] != 0) mk = 0;
        else if (cap[k] != 0 && sel[k] < n_ops[k]) begin
          if (((mk >> sel[k]) & 1) != 0) dp = 1;
          v[sel[k]] = d[k];
          mk = mk | (1 << sel[k]);
        end
        if (mk == (1 << n_ops[k]) - 1) ph = 1;
      end else if (ph == 1) begin
        rs = reduce(v, n_ops[k], md[k]);
        vo = 1; mk = 0; ph = 2;
      end else if (ack[k] != 0) begin
        vo = 0; ph = 0;
      end
      m_ph[k] <= ph; m_mask[k] <= mk; m_vo[k] <= vo; m_dup[k] <= dp; m_res[k] <= rs;
      m_vals[k] <= v;
    end
  end
  always @(negedge clock) begin
    if (chk_en)
      for (int k = 0; k < 2; k++) begin
        check(k, "ready", a_rdy[k], m_ph[k] == 0 ? 1 : 0);
        check(k, "valid", a_vld[k], m_vo[k]);
        check(k, "slot_valid", a_sv[k], m_mask[k]);
        check(k, "result", a_res[k], m_res[k]);
        check(k, "dup_err", a_dup[k], m_dup[k]);
      end
  end
  task automatic do_set(input int k, input int mdv, input int s[6], input int v[6],
                        input int n, input int exp, input bit do_ack);
    int lat = 0;
    md[k] = mdv;
    for (int i = 0; i < n; i++) begin
      cap[k] = 1; sel[k] = s[i]; d[k] = v[i];
      tick();
    end
    cap[k] = 0;
    while (a_vld[k] == 0 && lat < 5) begin
      tick();
      lat++;
    end
    check(k, "latency", lat, 1);
    check(k, "lit_result", a_res[k], exp);
    check(k, "model_result", m_res[k], exp);
    check(k, "lit_slot_valid", a_sv[k], 0);
    if (do_ack) begin
      ack[k] = 1;
      tick();
      ack[k] = 0;
      check(k, "valid_after_ack", a_vld[k], 0);
      check(k, "ready_after_ack", a_rdy[k], 1);
    end
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      cap[k] = 0; sel[k] = 0; d[k] = 0; abt[k] = 0; md[k] = 0; ack[k] = 0;
    end
    rst = 1;
    tick();
    tick();
    check(0, "rst_ready", a_rdy[0], 1);
    check(0, "rst_valid", a_vld[0], 0);
    check(0, "rst_slot_valid", a_sv[0], 0);
    check(0, "rst_result", a_res[0], 0);
    check(0, "rst_dup", a_dup[0], 0);
    rst = 0;
    chk_en = 1'b1;
    do_set(0, 0, '{0, 1, 2, 3, 0, 0}, '{3, 5, 7, 9, 0, 0}, 4, 24, 1);
    do_set(0, 1, '{2, 0, 3, 1, 0, 0}, '{3, 5, 7, 9, 0, 0}, 4, 9, 1);
    do_set(0, 2, '{0, 1, 2, 3, 0, 0}, '{15, 1, 8, 4, 0, 0}, 4, 1, 1);
    do_set(0, 3, '{0, 1, 2, 3, 0, 0}, '{15, 3, 5, 0, 0, 0}, 4, 9, 1);
    do_set(0, 0, '{0, 1, 2, 3, 0, 0}, '{15, 15, 15, 15, 0, 0}, 4, 60, 1);
    do_set(0, 0, '{0, 0, 1, 2, 3, 0}, '{2, 6, 1, 1, 1, 0}, 5, 9, 0);
    check(0, "lit_dup_set", a_dup[0], 1);
    for (int i = 0; i < 5; i++) begin
      cap[0] = 1; sel[0] = i % 4; d[0] = 15;
      tick();
    end
    cap[0] = 0;
    check(0, "hold_result", a_res[0], 9);
    check(0, "hold_valid", a_vld[0], 1);
    check(0, "hold_slot_valid", a_sv[0], 0);
    check(0, "hold_ready", a_rdy[0], 0);
    ack[0] = 1;
    tick();
    ack[0] = 0;
    cap[0] = 1; sel[0] = 0; d[0] = 1;
    tick();
    sel[0] = 1; d[0] = 2;
    tick();
    check(0, "pre_abort_slot_valid", a_sv[0], 3);
    abt[0] = 1; sel[0] = 2; d[0] = 3;
    tick();
    abt[0] = 0; cap[0] = 0;
    check(0, "abort_slot_valid", a_sv[0], 0);
    check(0, "abort_dup_kept", a_dup[0], 1);
    cap[0] = 1; sel[0] = 0; d[0] = 4;
    tick();
    sel[0] = 1; rst = 1;
    tick();
    rst = 0; cap[0] = 0;
    check(0, "midrst_slot_valid", a_sv[0], 0);
    check(0, "midrst_dup", a_dup[0], 0);
    tick();
    tick();
    check(0, "midrst_valid", a_vld[0], 0);
    cap[1] = 1; sel[1] = 3; d[1] = 200;
    tick();
    cap[1] = 0;
    check(1, "oor_slot_valid", a_sv[1], 0);
    check(1, "oor_dup", a_dup[1], 0);
    do_set(1, 0, '{0, 1, 2, 0, 0, 0}, '{255, 255, 255, 0, 0, 0}, 3, 765, 1);
    do_set(1, 2, '{2, 1, 0, 0, 0, 0}, '{40, 9, 200, 0, 0, 0}, 3, 9, 1);
    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
